inst_mem_responder: RTL and testbench

Memory-side responder for the instruction-fetch path. It accepts one read request at a time over a valid/ready address channel and waits a fixed, parameterised latency. It then returns a 32-bit instruction word over a valid/ready data channel together with a response code. Storage is an internal word array that the testbench or loader fills through a byte-strobed write port. The fetch unit sits on the requesting end of this interface.

---
 rtl/inst_mem_responder.sv | 127 ++++++++++++
 tb/tb_inst_mem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// Instruction-fetch memory responder: one outstanding read over valid/ready channels,
// fixed response latency, and a byte-strobed loader write port into the word array.
module inst_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_arvalid,
    output logic        o_arready,
    input  logic [31:0] i_araddr,
    output logic        o_rvalid,
    input  logic        i_rready,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_rresp,
    input  logic        i_wen,
    input  logic [31:0] i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] cap_addr;
    logic [31:0] cap_off;
    logic [31:0] wr_off;
    logic [1:0]  cap_resp;
    logic [31:0] cap_data;
    logic        unused_bits;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a} < END_ADDR);
    endfunction

    assign o_arready = (state == ST_IDLE) && !i_reset;

    // With zero latency the capture happens on the acceptance edge, so decode the live address.
    always_comb begin
        cap_addr = (state == ST_IDLE) ? i_araddr : addr_q;
        cap_off  = cap_addr - BASE_ADDR;
        cap_resp = 2'b00;
        cap_data = '0;
        if (cap_addr[1:0] != 2'b00) begin
            cap_resp = 2'b10;
        end else if (!in_range(cap_addr)) begin
            cap_resp = 2'b11;
        end else begin
            cap_data = mem[cap_off[IDX_W+1:2]];
        end
    end

    assign wr_off      = i_waddr - BASE_ADDR;
    assign unused_bits = ^{cap_off, wr_off};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
            o_rresp  <= 2'b00;
            addr_q   <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_arvalid) begin
                        addr_q <= i_araddr;
                        if (LATENCY == 0) begin
                            o_rdata  <= cap_data;
                            o_rresp  <= cap_resp;
                            o_rvalid <= 1'b1;
                            state    <= ST_RESP;
                        end else begin
                            cnt   <= 4'(LATENCY - 1);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        o_rdata  <= cap_data;
                        o_rresp  <= cap_resp;
                        o_rvalid <= 1'b1;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_rready) begin
                        o_rvalid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    o_rvalid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Array is never reset; capture above reads the pre-write word on a same-edge collision.
    always_ff @(posedge i_clock) begin
        if (i_wen && in_range(i_waddr)) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (i_wstrb[k]) begin
                    mem[wr_off[IDX_W+1:2]][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench for inst_mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a response is presented.
module tb_inst_mem_responder;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_arvalid;
    logic        o_arready;
    logic [31:0] i_araddr;
    logic        o_rvalid;
    logic        i_rready;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp;
    logic        i_wen;
    logic [31:0] i_waddr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;

    int n_checks = 0;
    int n_errors = 0;
    logic [33:0] exp_q[$];

    inst_mem_responder #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR(32'h8000_0000),
        .LATENCY(2)
    ) dut (
        .i_clock(clk),
        .i_reset(i_reset),
        .i_arvalid(i_arvalid),
        .o_arready(o_arready),
        .i_araddr(i_araddr),
        .o_rvalid(o_rvalid),
        .i_rready(i_rready),
        .o_rdata(o_rdata),
        .o_rresp(o_rresp),
        .i_wen(i_wen),
        .i_waddr(i_waddr),
        .i_wdata(i_wdata),
        .i_wstrb(i_wstrb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        i_wen = 1'b1; i_waddr = a; i_wdata = d; i_wstrb = s;
        tick();
        i_wen = 1'b0;
    endtask

    // Response monitor: a handshake pops, a stalled response must match the head entry.
    always @(negedge clk) begin
        if (!i_reset && o_rvalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_rvalid: got rdata=%h rresp=%b with nothing expected", o_rdata, o_rresp);
            end else if (i_rready) begin
                chk("resp_pop", 64'({o_rresp, o_rdata}), 64'(exp_q.pop_front()));
            end else begin
                chk("resp_hold", 64'({o_rresp, o_rdata}), 64'(exp_q[0]));
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input logic [1:0] resp, input logic [31:0] data,
                           input int hold);
        chk("arready_idle", 64'(o_arready), 64'd1);
        exp_q.push_back({resp, data});
        i_arvalid = 1'b1;
        i_araddr  = a;
        i_rready  = (hold == 0);
        tick();                                // E0
        i_araddr  = 32'hDEAD_BEEC;
        i_arvalid = (hold > 0);
        chk("rvalid_e0", 64'(o_rvalid), 64'd0);
        chk("arready_busy", 64'(o_arready), 64'd0);
        tick();                                // E1
        chk("rvalid_e1", 64'(o_rvalid), 64'd0);
        tick();                                // E2
        chk("rvalid_e2", 64'(o_rvalid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            chk("arready_resp", 64'(o_arready), 64'd0);
            tick();
            chk("rvalid_stall", 64'(o_rvalid), 64'd1);
        end
        i_rready  = 1'b1;
        i_arvalid = 1'b0;
        tick();                                // handshake edge
        chk("rvalid_after_hs", 64'(o_rvalid), 64'd0);
        chk("arready_after_hs", 64'(o_arready), 64'd1);
        i_rready = 1'b0;
    endtask

    task automatic rd_collide(input logic [31:0] a, input logic [31:0] wd, input int wr_edge,
                              input logic [31:0] expd);
        exp_q.push_back({2'b00, expd});
        i_arvalid = 1'b1;
        i_araddr  = a;
        i_rready  = 1'b1;
        tick();                                // E0
        i_arvalid = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            if (e == wr_edge) begin
                i_wen = 1'b1; i_waddr = a; i_wdata = wd; i_wstrb = 4'hF;
            end
            tick();
            i_wen = 1'b0;
        end
        chk("collide_rvalid", 64'(o_rvalid), 64'd1);
        tick();
        chk("collide_done", 64'(o_rvalid), 64'd0);
        i_rready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1; i_arvalid = 1'b0; i_araddr = '0; i_rready = 1'b0;
        i_wen = 1'b0; i_waddr = '0; i_wdata = '0; i_wstrb = '0;
        tick();
        wr(32'h8000_0000, 32'h0000_0413, 4'hF);    // write accepted during reset
        tick();
        chk("reset_rvalid", 64'(o_rvalid), 64'd0);
        chk("reset_rdata", 64'(o_rdata), 64'd0);
        chk("reset_rresp", 64'(o_rresp), 64'd0);
        chk("reset_arready", 64'(o_arready), 64'd0);
        i_reset = 1'b0;
        #1;
        chk("arready_post_reset", 64'(o_arready), 64'd1);

        do_read(32'h8000_0000, 2'b00, 32'h0000_0413, 0);
        wr(32'h8000_0004, 32'h0010_0093, 4'hF);
        do_read(32'h8000_0004, 2'b00, 32'h0010_0093, 5);

        do_read(32'h8000_0002, 2'b10, 32'h0, 0);
        do_read(32'h7FFF_FFFC, 2'b11, 32'h0, 0);
        do_read(32'h8000_1000, 2'b11, 32'h0, 0);
        do_read(32'h8000_1001, 2'b10, 32'h0, 0);
        wr(32'h8000_0FFC, 32'hCAFE_F00D, 4'hF);
        do_read(32'h8000_0FFC, 2'b00, 32'hCAFE_F00D, 0);

        wr(32'h8000_1000, 32'h1234_5678, 4'hF);    // out of range, must not alias word 0
        do_read(32'h8000_0000, 2'b00, 32'h0000_0413, 0);

        wr(32'h8000_0008, 32'hAABB_CCDD, 4'hF);
        wr(32'h8000_000B, 32'h1122_3344, 4'b0101);
        do_read(32'h8000_0008, 2'b00, 32'hAA22_CC44, 0);

        wr(32'h8000_0010, 32'h0000_0001, 4'hF);
        rd_collide(32'h8000_0010, 32'h0000_0002, 2, 32'h0000_0001);
        rd_collide(32'h8000_0010, 32'h0000_0003, 1, 32'h0000_0003);
        do_read(32'h8000_0010, 2'b00, 32'h0000_0003, 0);

        // reset while waiting
        exp_q.push_back({2'b00, 32'h0000_0413});
        i_arvalid = 1'b1; i_araddr = 32'h8000_0000;
        tick();
        i_arvalid = 1'b0; i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_wait_rvalid", 64'(o_rvalid), 64'd0);
        chk("rst_wait_arready", 64'(o_arready), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("rst_wait_no_late", 64'(o_rvalid), 64'd0);

        // reset while holding a response
        exp_q.push_back({2'b00, 32'h0010_0093});
        i_arvalid = 1'b1; i_araddr = 32'h8000_0004; i_rready = 1'b0;
        tick();
        i_arvalid = 1'b0;
        tick();
        tick();
        chk("rst_resp_pre", 64'(o_rvalid), 64'd1);
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_resp_rvalid", 64'(o_rvalid), 64'd0);
        chk("rst_resp_arready", 64'(o_arready), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("rst_resp_no_late", 64'(o_rvalid), 64'd0);

        do_read(32'h8000_0004, 2'b00, 32'h0010_0093, 0);

        for (int i = 0; i < 3; i++) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
